// File: rtl/cr_isf_ob_mon.sv
// cr_isf_ob_mon: ISF outbound monitor; 2-entry skid buffer with TLV frame checks, byte count and stall interrupt
// Ports: clk, rst_n (sync, active-low) | in_* AXI4-stream from ISF outbound | out_* AXI4-stream to next engine
//        stall_limit (0 disables) | frame_done, frame_bytes per completed frame | err_sot, err_nested, stall_int pulses
module cr_isf_ob_mon #(
    parameter int DATA_W  = 64,
    parameter int STRB_W  = 8,
    parameter int BCNT_W  = 24,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_tvalid,
    output logic               in_tready,
    input  logic               in_tlast,
    input  logic [DATA_W-1:0]  in_tdata,
    input  logic [STRB_W-1:0]  in_tstrb,
    input  logic [7:0]         in_tuser,
    output logic               out_tvalid,
    input  logic               out_tready,
    output logic               out_tlast,
    output logic [DATA_W-1:0]  out_tdata,
    output logic [STRB_W-1:0]  out_tstrb,
    output logic [7:0]         out_tuser,
    input  logic [STALL_W-1:0] stall_limit,
    output logic               frame_done,
    output logic [BCNT_W-1:0]  frame_bytes,
    output logic               err_sot,
    output logic               err_nested,
    output logic               stall_int
);
    localparam int BEAT_W = 1 + 8 + STRB_W + DATA_W;
    typedef enum logic {IDLE, IN_FRAME} state_t;
    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]         occ_q, occ_d;
    logic               in_tready_q, in_tready_d;
    logic [BCNT_W-1:0]  cnt_q, cnt_d, frame_bytes_q, frame_bytes_d, sat;
    logic [BCNT_W:0]    sum;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               frame_done_q, frame_done_d, err_sot_q, err_sot_d;
    logic               err_nested_q, err_nested_d, stall_int_q, stall_int_d;
    logic               push, pop, stall;
    logic [BEAT_W-1:0]  in_beat;
    assign in_beat = {in_tlast, in_tuser, in_tstrb, in_tdata};
    assign push    = in_tvalid & in_tready_q;
    assign pop     = (occ_q != 2'd0) & out_tready;
    assign stall   = (occ_q != 2'd0) & ~out_tready;
    always_comb begin
        occ_d         = occ_q + 2'(push) - 2'(pop);
        in_tready_d   = occ_d != 2'd2;
        // buf0 is always the head; buf1 only fills while the head is stuck
        buf0_d        = (pop && occ_q == 2'd2) ? buf1_q :
                        ((push && (occ_q == 2'd0 || pop)) ? in_beat : buf0_q);
        buf1_d        = (push && !pop && occ_q == 2'd1) ? in_beat : buf1_q;
        sum           = {1'b0, cnt_q} + (BCNT_W + 1)'($countones(in_tstrb));
        sat           = sum[BCNT_W] ? '1 : sum[BCNT_W-1:0];
        state_d       = push ? (in_tlast ? IDLE : IN_FRAME) : state_q;
        cnt_d         = push ? (in_tlast ? '0 : sat) : cnt_q;
        frame_done_d  = push & in_tlast;
        frame_bytes_d = (push & in_tlast) ? sat : frame_bytes_q;
        err_sot_d     = push & (state_q == IDLE) & ~in_tuser[0];
        err_nested_d  = push & (state_q == IN_FRAME) & in_tuser[0];
        stall_d       = stall ? ((&stall_q) ? stall_q : stall_q + STALL_W'(1)) : '0;
        // fire only on the transition onto the limit so a saturated/held count cannot re-fire
        stall_int_d   = stall & (stall_limit != '0) & (stall_d == stall_limit) & (stall_q != stall_limit);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            buf0_q        <= '0;
            buf1_q        <= '0;
            occ_q         <= 2'd0;
            in_tready_q   <= 1'b0;
            cnt_q         <= '0;
            frame_bytes_q <= '0;
            stall_q       <= '0;
            frame_done_q  <= 1'b0;
            err_sot_q     <= 1'b0;
            err_nested_q  <= 1'b0;
            stall_int_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
            occ_q         <= occ_d;
            in_tready_q   <= in_tready_d;
            cnt_q         <= cnt_d;
            frame_bytes_q <= frame_bytes_d;
            stall_q       <= stall_d;
            frame_done_q  <= frame_done_d;
            err_sot_q     <= err_sot_d;
            err_nested_q  <= err_nested_d;
            stall_int_q   <= stall_int_d;
        end
    end
    assign in_tready = in_tready_q;
    assign out_tvalid = occ_q != 2'd0;
    assign {out_tlast, out_tuser, out_tstrb, out_tdata} = buf0_q;
    assign frame_done = frame_done_q;
    assign frame_bytes = frame_bytes_q;
    assign err_sot = err_sot_q;
    assign err_nested = err_nested_q;
    assign stall_int = stall_int_q;
endmodule

// File: tb/tb_cr_isf_ob_mon.sv
// tb_cr_isf_ob_mon: self-checking bench for cr_isf_ob_mon (vector table, corner sequences, random vs queue model)
module tb_cr_isf_ob_mon;
    logic        clk = 1'b0;
    logic        rst_n, in_tvalid, in_tready, in_tlast, out_tvalid, out_tready, out_tlast;
    logic [63:0] in_tdata, out_tdata;
    logic [7:0]  in_tstrb, in_tuser, out_tstrb, out_tuser;
    logic [15:0] stall_limit;
    logic        frame_done, err_sot, err_nested, stall_int;
    logic [23:0] frame_bytes;

    always #5 clk = ~clk;

    cr_isf_ob_mon dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tstrb(in_tstrb), .in_tuser(in_tuser),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tdata(out_tdata), .out_tstrb(out_tstrb), .out_tuser(out_tuser),
        .stall_limit(stall_limit), .frame_done(frame_done), .frame_bytes(frame_bytes),
        .err_sot(err_sot), .err_nested(err_nested), .stall_int(stall_int)
    );

    typedef struct packed {
        logic        last;
        logic [7:0]  user;
        logic [7:0]  strb;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        bit          v;
        bit          last;
        logic [7:0]  user;
        logic [7:0]  strb;
        logic [63:0] data;
        bit          e_v;
        bit          e_done;
        int          e_fb;
        bit          e_es;
        bit          e_en;
    } vec_t;

    int    n_chk = 0, n_fail = 0;
    beat_t mq[$];
    beat_t got[$];
    bit    m_rdy, m_inf, m_done, m_es, m_en, m_si;
    int    m_cnt, m_fb, m_sc, n_si;

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, beat_t b);
        in_tvalid = v;
        {in_tlast, in_tuser, in_tstrb, in_tdata} = b;
    endtask

    // One clock: advance the reference model on the edge, then compare every output against it
    task automatic cyc();
        bit    push, pop;
        int    nc;
        beat_t b;
        b = {in_tlast, in_tuser, in_tstrb, in_tdata};
        if (rst_n && out_tvalid && out_tready) got.push_back({out_tlast, out_tuser, out_tstrb, out_tdata});
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_rdy = 0; m_inf = 0; m_cnt = 0; m_fb = 0; m_sc = 0;
            m_done = 0; m_es = 0; m_en = 0; m_si = 0;
        end else begin
            push = in_tvalid && m_rdy;
            pop = mq.size() > 0 && out_tready;
            m_si = 0;
            if (mq.size() > 0 && !out_tready) begin
                nc = (m_sc == 65535) ? m_sc : m_sc + 1;
                m_si = (stall_limit != 0) && (nc == int'(stall_limit)) && (m_sc != int'(stall_limit));
                m_sc = nc;
            end else m_sc = 0;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(b);
            m_rdy = mq.size() < 2;
            m_done = 0; m_es = 0; m_en = 0;
            if (push) begin
                m_es = !m_inf && !b.user[0];
                m_en = m_inf && b.user[0];
                m_cnt = m_cnt + $countones(b.strb);
                if (m_cnt > 24'hFFFFFF) m_cnt = 24'hFFFFFF;
                if (b.last) begin
                    m_done = 1; m_fb = m_cnt; m_cnt = 0; m_inf = 0;
                end else m_inf = 1;
            end
        end
        #1;
        if (stall_int) n_si++;
        chk("in_tready", in_tready, m_rdy);
        chk("out_tvalid", out_tvalid, mq.size() > 0);
        chk("frame_done", frame_done, m_done);
        chk("frame_bytes", frame_bytes, m_fb);
        chk("err_sot", err_sot, m_es);
        chk("err_nested", err_nested, m_en);
        chk("stall_int", stall_int, m_si);
        if (mq.size() > 0) chk("out_beat", {out_tlast, out_tuser, out_tstrb, out_tdata}, mq[0]);
    endtask

    task automatic stall_run(logic [15:0] lim, int exp_n, int exp_at);
        int at = 0;
        stall_limit = lim;
        out_tready = 0;
        drive(1, {1'b1, 8'h03, 8'hFF, 64'h5000 + 64'(lim)});
        cyc();
        in_tvalid = 0;
        n_si = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (stall_int) at = i;
        end
        chk("stall_pulses", n_si, exp_n);
        chk("stall_at", at, exp_at);
        out_tready = 1;
        cyc();
        cyc();
    endtask

    vec_t  tbl[12];
    beat_t bp[3];
    int    k;
    bit    pre;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 1, 8'h03, 8'hFF, 64'h1111, 1, 1, 8,  0, 0};
        tbl[1]  = '{0, 0, 8'h00, 8'h00, 64'h0,    0, 0, 8,  0, 0};
        tbl[2]  = '{1, 0, 8'h01, 8'hFF, 64'h2001, 1, 0, 8,  0, 0};
        tbl[3]  = '{1, 0, 8'h00, 8'hFF, 64'h2002, 1, 0, 8,  0, 0};
        tbl[4]  = '{1, 0, 8'h00, 8'hFF, 64'h2003, 1, 0, 8,  0, 0};
        tbl[5]  = '{1, 1, 8'h02, 8'h0F, 64'h2004, 1, 1, 28, 0, 0};
        tbl[6]  = '{0, 0, 8'h00, 8'h00, 64'h0,    0, 0, 28, 0, 0};
        tbl[7]  = '{1, 0, 8'h00, 8'h03, 64'h3001, 1, 0, 28, 1, 0};
        tbl[8]  = '{1, 0, 8'h00, 8'hFF, 64'h3002, 1, 0, 28, 0, 0};
        tbl[9]  = '{1, 0, 8'h01, 8'h01, 64'h3003, 1, 0, 28, 0, 1};
        tbl[10] = '{1, 1, 8'h02, 8'hF0, 64'h3004, 1, 1, 15, 0, 0};
        tbl[11] = '{0, 0, 8'h00, 8'h00, 64'h0,    0, 0, 15, 0, 0};
        rst_n = 0; out_tready = 1; stall_limit = 0;
        drive(0, '0);
        repeat (3) cyc();
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_in_tready", in_tready, 0);
        chk("rst_out_tdata", out_tdata, 0);
        chk("rst_frame_bytes", frame_bytes, 0);
        rst_n = 1;
        cyc();
        chk("post_rst_in_tready", in_tready, 1);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, {tbl[i].last, tbl[i].user, tbl[i].strb, tbl[i].data});
            cyc();
            chk("tbl_in_tready", in_tready, 1);
            chk("tbl_out_tvalid", out_tvalid, tbl[i].e_v);
            chk("tbl_frame_done", frame_done, tbl[i].e_done);
            chk("tbl_frame_bytes", frame_bytes, tbl[i].e_fb);
            chk("tbl_err_sot", err_sot, tbl[i].e_es);
            chk("tbl_err_nested", err_nested, tbl[i].e_en);
            if (tbl[i].e_v) chk("tbl_out_tdata", out_tdata, tbl[i].data);
        end

        bp[0] = {1'b0, 8'h01, 8'hFF, 64'h4001};
        bp[1] = {1'b0, 8'h00, 8'hFF, 64'h4002};
        bp[2] = {1'b1, 8'h02, 8'hFF, 64'h4003};
        got.delete();
        out_tready = 0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            drive(k < 3, k < 3 ? bp[k] : '0);
            pre = in_tvalid && in_tready;
            cyc();
            if (pre) k++;
        end
        chk("bp_accepts", k, 2);
        chk("bp_in_tready", in_tready, 0);
        out_tready = 1;
        for (int i = 0; i < 20 && !(k == 3 && got.size() == 3); i++) begin
            drive(k < 3, k < 3 ? bp[k] : '0);
            pre = in_tvalid && in_tready;
            cyc();
            if (pre) k++;
        end
        in_tvalid = 0;
        cyc();
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++) if (i < got.size()) chk("bp_order", got[i], bp[i]);
        chk("bp_frame_bytes", frame_bytes, 24);

        stall_run(16'd5, 1, 5);
        stall_run(16'd0, 0, 0);

        out_tready = 0;
        drive(1, {1'b0, 8'h01, 8'hFF, 64'h6001});
        cyc();
        drive(1, {1'b0, 8'h00, 8'hFF, 64'h6002});
        cyc();
        in_tvalid = 0;
        rst_n = 0;
        cyc();
        chk("rstmid_out_tvalid", out_tvalid, 0);
        chk("rstmid_frame_bytes", frame_bytes, 0);
        chk("rstmid_in_tready", in_tready, 0);
        chk("rstmid_frame_done", frame_done, 0);
        rst_n = 1; out_tready = 1;
        cyc();
        drive(1, {1'b0, 8'h01, 8'h0F, 64'h7001});
        cyc();
        drive(1, {1'b1, 8'h02, 8'h03, 64'h7002});
        cyc();
        chk("rstmid_new_done", frame_done, 1);
        chk("rstmid_new_bytes", frame_bytes, 6);
        chk("rstmid_no_err", err_sot | err_nested, 0);
        in_tvalid = 0;
        cyc();

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (i % 100 == 0) stall_limit = 16'($urandom_range(0, 4));
            out_tready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 1), {($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom),
                                         {$urandom, $urandom}});
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
